ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
Keyboard-path stage directly upstream of the random-number latch. It consumes the byte stream from the PS/2 byte receiver and tracks the make/break state of one configured key. It drives a clean level (key_is_pressed) and single-cycle make/break pulses. key_is_pressed feeds the random latch's edge input, so one physical press produces exactly one rising edge, regardless of typematic repeats.

Parameters:
KEY_CODE, 8'h29, scan code (set 2) of the tracked key; default is Space
KEY_EXTENDED, 1'b0, 1 = key uses the E0 prefix, 0 = plain code
TIMEOUT_CYCLES, 16'd50000, prefix-abandon limit in clk cycles; used only with KEY_PREFIX_TIMEOUT_EN

Ports:
clk  input  1  system clock
resetN  input  1  synchronous reset, active-high (1 = reset), sampled on posedge clk
din  input  8  received scan-code byte
din_new  input  1  one-cycle strobe; din is valid when this is high
make  output  1  one-cycle pulse on a press transition
brake  output  1  one-cycle pulse on a release transition
key_is_pressed  output  1  level, high while the key is held

Behaviour:
- Reset: when resetN=1 at a posedge, state <= IDLE, key_is_pressed=0, make=0, brake=0. Reset dominates din_new in the same cycle. Reset mid-sequence discards any partial prefix.
- All outputs are registered. The response appears on the cycle after din_new=1 is sampled, so latency is 1 clk.
- Bytes are processed only when din_new=1. If din_new=0, the state holds (timeout feature excepted) and make/brake return to 0.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0_F0.
- State transitions on din_new=1:
  - din=8'hE0 from any state -> GOT_E0. This restarts the prefix.
  - din=8'hF0 in IDLE -> GOT_F0.
  - din=8'hF0 in GOT_E0 -> GOT_E0_F0.
  - din=8'hF0 in GOT_F0 or GOT_E0_F0 -> state unchanged.
  - Any other byte -> evaluated as a data byte, then -> IDLE.
- Data-byte evaluation. A match requires din==KEY_CODE and the prefix kind to agree with KEY_EXTENDED:
  - IDLE matches only if KEY_EXTENDED=0 and GOT_E0 matches only if KEY_EXTENDED=1. A match is a press.
  - GOT_F0 matches only if KEY_EXTENDED=0 and GOT_E0_F0 matches only if KEY_EXTENDED=1. A match is a release.
- Press with key_is_pressed=0: key_is_pressed <= 1 and make <= 1 for one cycle.
- Press with key_is_pressed=1 (typematic repeat): no pulse, level unchanged.
- Release with key_is_pressed=1: key_is_pressed <= 0 and brake <= 1 for one cycle.
- Release with key_is_pressed=0: ignored, no pulse.
- Non-matching data bytes (other keys, E1 pause bytes, AA/FA/FE responses) leave outputs unchanged and return to IDLE.
- make and brake are never high in the same cycle.
- Back-to-back din_new strobes on consecutive cycles are accepted; each byte is processed in its own cycle.

Optional Feature:
KEY_PREFIX_TIMEOUT_EN
- Defined: a 16-bit counter resets on every din_new and increments each cycle while the state is not IDLE. When it reaches TIMEOUT_CYCLES-1 with no din_new, the FSM returns to IDLE with no output change. A din_new arriving in that same cycle takes priority over the timeout.
- Not defined: there is no counter, and a prefix state is held indefinitely until the next byte.

Test Plan:
1. Reset while in GOT_F0 (after F0), then din=29 -> state IDLE after reset; the 29 produces make=1 for one cycle and key_is_pressed=1.
2. Default params; stream 29, 29, 29, F0, 29 -> make pulses once, on the cycle after the first 29; key_is_pressed stays high through the repeats; brake pulses once, on the cycle after the final 29; key_is_pressed=0 afterward.
3. Default params; stream E0, 29 then E0, F0, 29 -> no make/brake and key_is_pressed stays 0 (the extended prefix does not match).
4. KEY_EXTENDED=1, KEY_CODE=8'h75; stream 75, E0, 75, E0, F0, 75 -> the plain 75 is ignored; make follows the second 75; brake follows the third; final key_is_pressed=0.
5. Default params; stream F0, E0, 29 -> the prefix restarts at E0, so the 29 is treated as extended; no pulse; state IDLE.
6. KEY_PREFIX_TIMEOUT_EN, TIMEOUT_CYCLES=10; din=F0, idle 12 cycles, din=29 -> the timeout returns the FSM to IDLE, so the 29 is a press: make=1 and key_is_pressed=1.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Tracks make/break of one PS/2 set-2 scan code and emits a clean level plus make/brake pulses.
// Optional prefix-abandon timeout enabled by defining KEY_PREFIX_TIMEOUT_EN.
module ps2_key_tracker #(
  parameter logic [7:0]  KEY_CODE       = 8'h29,
  parameter logic        KEY_EXTENDED   = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic       make,
  output logic       brake,
  output logic       key_is_pressed
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GOT_E0    = 2'd1,
    GOT_F0    = 2'd2,
    GOT_E0_F0 = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   pressed_q, pressed_d;
  logic   make_q, make_d;
  logic   brake_q, brake_d;
  logic   code_hit;
  logic   is_press;
  logic   is_release;
  logic   timeout;

`ifdef KEY_PREFIX_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout = !din_new && (state_q != IDLE) && (cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    cnt_d = '0;
    if (!din_new && (state_q != IDLE) && !timeout) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Prefix kind must agree with KEY_EXTENDED for a data byte to count.
  assign code_hit   = (din == KEY_CODE);
  assign is_press   = code_hit && (KEY_EXTENDED ? (state_q == GOT_E0) : (state_q == IDLE));
  assign is_release = code_hit && (KEY_EXTENDED ? (state_q == GOT_E0_F0) : (state_q == GOT_F0));

  always_comb begin
    state_d   = state_q;
    pressed_d = pressed_q;
    make_d    = 1'b0;
    brake_d   = 1'b0;
    if (din_new) begin
      if (din == 8'hE0) begin
        state_d = GOT_E0;
      end else if (din == 8'hF0) begin
        case (state_q)
          IDLE:    state_d = GOT_F0;
          GOT_E0:  state_d = GOT_E0_F0;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = IDLE;
        if (is_press && !pressed_q) begin
          pressed_d = 1'b1;
          make_d    = 1'b1;
        end else if (is_release && pressed_q) begin
          pressed_d = 1'b0;
          brake_d   = 1'b1;
        end
      end
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q   <= IDLE;
      pressed_q <= 1'b0;
      make_q    <= 1'b0;
      brake_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pressed_q <= pressed_d;
      make_q    <= make_d;
      brake_q   <= brake_d;
    end
  end

  assign make           = make_q;
  assign brake          = brake_q;
  assign key_is_pressed = pressed_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: default Space key instance plus an extended (E0 75) instance.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] din;
  logic       din_new;
  logic       make_a, brake_a, kp_a;
  logic       make_b, brake_b, kp_b;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .KEY_CODE(8'h29), .KEY_EXTENDED(1'b0), .TIMEOUT_CYCLES(16'd10)
  ) dut (
    .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
    .make(make_a), .brake(brake_a), .key_is_pressed(kp_a)
  );

  ps2_key_tracker #(
    .KEY_CODE(8'h75), .KEY_EXTENDED(1'b1), .TIMEOUT_CYCLES(16'd10)
  ) dut_ext (
    .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
    .make(make_b), .brake(brake_b), .key_is_pressed(kp_b)
  );

  // Compares {make, brake, key_is_pressed} triples.
  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got mbk=%b exp mbk=%b", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din     = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
  endtask

  initial begin
    resetN  = 1'b1;
    din     = 8'h00;
    din_new = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a", {make_a, brake_a, kp_a}, 3'b000);
    chk("rst_b", {make_b, brake_b, kp_b}, 3'b000);
    resetN = 1'b0;

    // reset dominates a simultaneous strobe
    @(negedge clk);
    resetN = 1'b1; din = 8'h29; din_new = 1'b1;
    @(negedge clk);
    resetN = 1'b0; din_new = 1'b0;
    chk("rst_dom", {make_a, brake_a, kp_a}, 3'b000);

    // test 1: reset mid-prefix
    send(8'hF0);
    @(negedge clk); resetN = 1'b1;
    @(negedge clk); resetN = 1'b0;
    chk("t1_after_rst", {make_a, brake_a, kp_a}, 3'b000);
    send(8'h29);
    chk("t1_make", {make_a, brake_a, kp_a}, 3'b101);
    @(negedge clk);
    chk("t1_pulse_end", {make_a, brake_a, kp_a}, 3'b001);
    send(8'hF0);
    send(8'h29);
    chk("t1_brake", {make_a, brake_a, kp_a}, 3'b010);

    // test 2: typematic repeats
    send(8'h29); chk("t2_make", {make_a, brake_a, kp_a}, 3'b101);
    send(8'h29); chk("t2_rep1", {make_a, brake_a, kp_a}, 3'b001);
    send(8'h29); chk("t2_rep2", {make_a, brake_a, kp_a}, 3'b001);
    send(8'hF0); chk("t2_f0", {make_a, brake_a, kp_a}, 3'b001);
    send(8'h29); chk("t2_brake", {make_a, brake_a, kp_a}, 3'b010);
    @(negedge clk);
    chk("t2_idle", {make_a, brake_a, kp_a}, 3'b000);

    // test 3: extended prefix does not match plain key
    send(8'hE0); chk("t3_e0", {make_a, brake_a, kp_a}, 3'b000);
    send(8'h29); chk("t3_ext_press", {make_a, brake_a, kp_a}, 3'b000);
    send(8'hE0);
    send(8'hF0);
    send(8'h29); chk("t3_ext_rel", {make_a, brake_a, kp_a}, 3'b000);

    // test 4: extended key instance
    send(8'h75); chk("t4_plain", {make_b, brake_b, kp_b}, 3'b000);
    send(8'hE0);
    send(8'h75); chk("t4_make", {make_b, brake_b, kp_b}, 3'b101);
    send(8'hE0);
    send(8'hF0);
    send(8'h75); chk("t4_brake", {make_b, brake_b, kp_b}, 3'b010);
    @(negedge clk);
    chk("t4_idle", {make_b, brake_b, kp_b}, 3'b000);
    chk("t4_dflt_quiet", {make_a, brake_a, kp_a}, 3'b000);

    // test 5: E0 restarts a pending F0 prefix
    send(8'hF0);
    send(8'hE0);
    send(8'h29); chk("t5_no_pulse", {make_a, brake_a, kp_a}, 3'b000);
    send(8'h29); chk("t5_idle_press", {make_a, brake_a, kp_a}, 3'b101);
    send(8'hF0);
    send(8'h29); chk("t5_rel", {make_a, brake_a, kp_a}, 3'b010);

    // back-to-back strobes: press, F0, release on consecutive cycles
    @(negedge clk);
    din = 8'h29; din_new = 1'b1;
    @(negedge clk);
    chk("b2b_make", {make_a, brake_a, kp_a}, 3'b101);
    din = 8'hF0;
    @(negedge clk);
    chk("b2b_f0", {make_a, brake_a, kp_a}, 3'b001);
    din = 8'h29;
    @(negedge clk);
    chk("b2b_brake", {make_a, brake_a, kp_a}, 3'b010);
    din_new = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {make_a, brake_a, kp_a}, 3'b000);

    // test 6: long gap after F0
    send(8'hF0);
    repeat (12) @(negedge clk);
    send(8'h29);
`ifdef KEY_PREFIX_TIMEOUT_EN
    chk("t6_timeout_press", {make_a, brake_a, kp_a}, 3'b101);
    send(8'hF0);
    send(8'h29);
    chk("t6_rel", {make_a, brake_a, kp_a}, 3'b010);
`else
    chk("t6_prefix_held", {make_a, brake_a, kp_a}, 3'b000);
    send(8'h29);
    chk("t6_then_press", {make_a, brake_a, kp_a}, 3'b101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
